instr_issue: RTL and testbench

Instruction issue unit that sits in front of the control unit (CU) and drives its 20-bit `instr` input. It holds a small writable program memory and steps a program counter. It presents each instruction word stable for exactly the number of cycles the CU needs to decode and complete it. It stops on a halt word or at the end of memory, and reports progress via `pc`, `busy` and `halted`.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_rom.sv | 27 ++
 rtl/instr_issue.sv | 140 ++++++++++++++
 tb/tb_instr_issue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issue path in front of the CU.
// Holds the word/address geometry, the slot length, where the type field
// sits in an instruction word, the type encodings and the issue FSM states.
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int ADDR_BITS   = 5;
  localparam int SLOT_CYCLES = 3;
  localparam int MEM_DEPTH   = 1 << ADDR_BITS;
  localparam int CNT_BITS    = $clog2(SLOT_CYCLES);

  // Type field position inside an instruction word
  localparam int TYPE_MSB = 19;
  localparam int TYPE_LSB = 18;

  localparam logic [1:0] TYPE_HALT  = 2'b00;
  localparam logic [1:0] TYPE_STD   = 2'b01;
  localparam logic [1:0] TYPE_LOAD  = 2'b10;
  localparam logic [1:0] TYPE_STORE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ISSUE,
    ST_HALT
  } issue_state_e;

  // A word whose type field is 00 keeps the CU parked, so it ends a program.
  function automatic logic is_halt_word(input logic [INSTR_WIDTH-1:0] word);
    return word[TYPE_MSB:TYPE_LSB] == TYPE_HALT;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Writable program memory: 2^ADDR_BITS words of INSTR_WIDTH bits.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata
// asynchronous read port. Contents are deliberately not reset.
module instr_rom
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read: a write on the same edge as a fetch is seen only
  // by later fetches, so the fetch gets the pre-write contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit feeding the CU instr input.
// Ports: clk, rst (sync, active-high), start (pulse, issue from address 0),
// prog_we/prog_addr/prog_data (program load, only while idle or halted),
// instr (registered word to CU), pc (address of word on instr),
// busy (issuing), halted (sticky end-of-program flag).
// The first word is held SLOT_CYCLES+1 cycles (extra PRIME cycle lets the CU
// leave reset), each later word exactly SLOT_CYCLES cycles.
module instr_issue
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   halted
);

  issue_state_e           state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  logic                   stopped;
  logic                   rom_we;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [ADDR_BITS-1:0]   pc_inc;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   slot_end;
  logic                   end_of_prog;

  // Memory only changes when no program is running.
  assign stopped  = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign rom_we   = prog_we && stopped;
  assign pc_inc   = pc_q + ADDR_BITS'(1);
  // Single read port: address 0 for a start fetch, otherwise the next word.
  assign rd_addr  = stopped ? '0 : pc_inc;
  assign slot_end = (cnt_q == CNT_BITS'(SLOT_CYCLES - 1));
  // No wrap-around past the top address.
  assign end_of_prog = (pc_q == '1) || is_halt_word(rd_data);

  instr_rom u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = is_halt_word(rd_data) ? ST_HALT : ST_PRIME;
        end
      end
      ST_PRIME: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (slot_end && end_of_prog) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d  = '0;
          cnt_d = '0;
          if (is_halt_word(rd_data)) begin
            instr_d  = '0;
            busy_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            instr_d  = rd_data;
            busy_d   = 1'b1;
            halted_d = 1'b0;
          end
        end
      end
      ST_PRIME: cnt_d = '0;
      ST_ISSUE: begin
        if (slot_end) begin
          cnt_d = '0;
          if (end_of_prog) begin
            instr_d  = '0;
            busy_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            instr_d = rd_data;
            pc_d    = pc_inc;
          end
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: ;
    endcase
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;

  always #5 clk = ~clk;

  instr_issue dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .instr     (instr),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  // Reference copy of program memory
  logic [19:0] model_mem [32];
  int n_checks = 0;
  int n_pass   = 0;
  int bc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a[4:0];
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    model_mem[a] = d;
  endtask

  // Pulses start, then checks every cycle against a schedule built from the
  // program: issued words are 0..first halt word (or end of memory); word 0
  // lasts 4 cycles, others 3; afterwards instr=0, halted, pc=last issued.
  task automatic run_prog(input string name, input int inject_cycle,
                          input bit wr_with_start, input logic [19:0] wr_data,
                          output int busy_cnt);
    logic [19:0] e_instr[$];
    logic [4:0]  e_pc[$];
    bit          e_busy[$];
    int          n_words;
    int          last;
    n_words = 0;
    while (n_words < 32 && model_mem[n_words][19:18] != 2'b00) n_words++;
    for (int k = 0; k < n_words; k++) begin
      for (int h = 0; h < ((k == 0) ? 4 : 3); h++) begin
        e_instr.push_back(model_mem[k]);
        e_pc.push_back(5'(k));
        e_busy.push_back(1'b1);
      end
    end
    last = (n_words == 0) ? 0 : n_words - 1;
    for (int h = 0; h < 3; h++) begin
      e_instr.push_back(20'h0);
      e_pc.push_back(5'(last));
      e_busy.push_back(1'b0);
    end

    start = 1'b1;
    if (wr_with_start) begin
      prog_we   = 1'b1;
      prog_addr = 5'd0;
      prog_data = wr_data;
    end
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    if (wr_with_start) model_mem[0] = wr_data;

    busy_cnt = 0;
    for (int c = 0; c < e_instr.size(); c++) begin
      check({name, ".instr"},  32'(instr),  32'(e_instr[c]));
      check({name, ".pc"},     32'(pc),     32'(e_pc[c]));
      check({name, ".busy"},   32'(busy),   32'(e_busy[c]));
      check({name, ".halted"}, 32'(halted), 32'(!e_busy[c]));
      if (busy) busy_cnt++;
      if (c == inject_cycle) begin
        prog_we   = 1'b1;
        prog_addr = 5'd1;
        prog_data = 20'hFFFFF;
        start     = 1'b1;
      end
      tick();
      prog_we = 1'b0;
      start   = 1'b0;
    end
    $display("run %s: words=%0d busy_cycles=%0d", name, n_words, busy_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick();
    tick();
    check("rst.instr", 32'(instr), 0);
    check("rst.pc", 32'(pc), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.halted", 32'(halted), 0);
    rst = 1'b0;
    tick();

    // Single std_op then halt
    write_word(0, 20'h52101);
    write_word(1, 20'h00000);
    run_prog("single", -1, 1'b0, 20'h0, bc);
    check("single.busy_cycles", 32'(bc), 4);

    // Three words then halt: 4/3/3
    write_word(0, 20'h41201);
    write_word(1, 20'h80301);
    write_word(2, 20'hC0401);
    write_word(3, 20'h00000);
    run_prog("three", -1, 1'b0, 20'h0, bc);
    check("three.busy_cycles", 32'(bc), 10);

    // Halt at address 0
    write_word(0, 20'h00000);
    run_prog("halt0", -1, 1'b0, 20'h0, bc);
    check("halt0.busy_cycles", 32'(bc), 0);

    // Full memory, no wrap
    for (int i = 0; i < 32; i++) write_word(i, 20'h40000 | 20'(i));
    run_prog("full", -1, 1'b0, 20'h0, bc);
    check("full.busy_cycles", 32'(bc), 97);

    // Reset two cycles after start
    write_word(0, 20'h41201);
    write_word(1, 20'h80301);
    write_word(2, 20'hC0401);
    write_word(3, 20'h00000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.instr", 32'(instr), 0);
    check("midrst.pc", 32'(pc), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.halted", 32'(halted), 0);
    run_prog("replay", -1, 1'b0, 20'h0, bc);

    // Write and start during ISSUE are ignored; rerun shows original mem[1]
    run_prog("inject", 5, 1'b0, 20'h0, bc);
    run_prog("after_inject", -1, 1'b0, 20'h0, bc);

    // Write to mem[0] with start: fetch sees old word, next run sees new
    run_prog("wr_start", -1, 1'b1, 20'h71234, bc);
    run_prog("wr_check", -1, 1'b0, 20'h0, bc);

    // Random programs
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++) begin
        logic [19:0] w;
        w = 20'($urandom);
        if (i < len) w[19:18] = 2'($urandom_range(1, 3));
        else if (i == len) w[19:18] = 2'b00;
        write_word(i, w);
      end
      run_prog($sformatf("rand%0d", r), -1, 1'b0, 20'h0, bc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
